matvec_load_ctrl: RTL and testbench
===================================

Name: matvec_load_ctrl

Overview:
- Parametrised fetch/sequence controller for the matrix-vector MAC datapath. It is the successor to the hard-wired FILL/EXEC/DONE sequencing.
- Acts as an Avalon-MM read master on the memory wrapper. Fetches one vector line and ROWS matrix lines, and serialises each line element-by-element into the B FIFO or the per-row A FIFOs.
- Then drives the execute window and reports completion.
- Sits between mem_wrapper and the mat-vec MAC array in the top level.

Parameters:
DATA_WIDTH, 8, element width in bits
COLS, 8, elements per line (vector length); line width = DATA_WIDTH*COLS
ROWS, 8, number of matrix rows / A FIFOs
ADDR_WIDTH, 32, Avalon address width
BASE_ADDR, 0, address of vector line; matrix row r is at BASE_ADDR + (r+1)*ADDR_INCR
ADDR_INCR, 1, address step between lines
DRAIN_CYCLES, 8, extra execute cycles after the last FIFO read, for array skew

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin a job; sampled only in IDLE or DONE
busy  out  1  high in every state except IDLE and DONE
done  out  1  level, high while in DONE
err  out  1  timeout error flag, held until the next accepted start
avm_address  out  ADDR_WIDTH  read address
avm_read  out  1  read request
avm_readdata  in  DATA_WIDTH*COLS  returned line
avm_readdatavalid  in  1  readdata valid
avm_waitrequest  in  1  slave stall
mac_clr  out  1  one-cycle accumulator clear
b_wren  out  1  B FIFO write strobe
b_data  out  DATA_WIDTH  B FIFO data
a_wren  out  ROWS  one-hot A FIFO write strobes
a_data  out  DATA_WIDTH  shared A FIFO data
mac_en  out  1  FIFO read / MAC enable during execute

Behaviour:
- Reset, and the IDLE state: all outputs are 0 and avm_address = BASE_ADDR. The line counter L and element counter E are 0.
- Reset while in any state forces IDLE on the next edge. A read response arriving after reset is ignored.
- States: IDLE, REQ, WAIT, SHIFT, EXEC, DONE.
- IDLE/DONE -> REQ when start=1.
  - mac_clr=1 for exactly the first REQ cycle.
  - err is cleared. L=0.
- REQ:
  - avm_read=1, avm_address = BASE_ADDR + L*ADDR_INCR.
  - Address is held stable while avm_waitrequest=1.
  - The request is accepted in the cycle where avm_read=1 and avm_waitrequest=0. Next state is WAIT, with avm_read=0.
- WAIT:
  - On avm_readdatavalid=1, capture avm_readdata into the line register and go to SHIFT with E=0.
  - readdatavalid in any other state is ignored.
- SHIFT: runs exactly COLS cycles.
  - Cycle E emits element E = line[E*DATA_WIDTH +: DATA_WIDTH], so element 0 (the LSBs) goes first.
  - L=0: b_wren=1 and b_data = element.
  - L>=1: a_wren[L-1]=1 and a_data = element. All other strobes are 0.
  - After element COLS-1: if L<ROWS, increment L and go to REQ. Otherwise go to EXEC.
- EXEC:
  - mac_en=1 for COLS cycles, then 0 for DRAIN_CYCLES cycles.
  - Then go to DONE.
- DONE: done=1, busy=0. Remain here until start.
- start while busy is ignored.
- Total strobes per job: COLS B writes and COLS*ROWS A writes.
- With zero-wait memory of latency N, each line takes 1 + N + COLS cycles.
- Single outstanding read only. The next REQ never overlaps a pending response.

Optional Feature:
- Macro: MATVEC_LOAD_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles spent in REQ and WAIT for the current line. It restarts at each REQ entry.
  - If it reaches 1023 before readdatavalid is captured: next state is DONE, err=1, avm_read=0, no further strobes.
- Undefined:
  - No counter is built and err is tied 0.
  - The controller waits indefinitely.

Test Plan:
- Reset/idle: hold rst 3 cycles, then release with start=0 -> all outputs 0, avm_address=BASE_ADDR, stays in IDLE.
- Nominal job: defaults; memory returns line k = {8{8'(k+1)}} with latency 1, no waitrequest.
  - Expect mac_clr for 1 cycle and 8 b_wren with data 0x01.
  - Expect 8 a_wren[r] pulses with data r+2 for each r.
  - Expect addresses 0..8, then mac_en 8 cycles, then 8 idle cycles, then done=1.
  - Total 9*10+16+1 cycles.
- Element order: line 0 = 0x0706050403020100 -> b_data sequence 0x00,0x01,...,0x07.
- Waitrequest stall: hold avm_waitrequest=1 for 5 cycles on line 3.
  - Expect avm_read high and avm_address=3 throughout, exactly one accept, and correct a_wren[2] data.
- Mid-job reset: assert rst during SHIFT of line 4 -> next cycle IDLE, all strobes 0. A readdatavalid pulse afterwards causes no strobes. A new start completes a full job.
- Timeout (macro on): never assert readdatavalid for line 2 -> after 1023 cycles done=1, err=1, no a_wren[1]. A new start clears err.

Source files
------------

// File: rtl/matvec_load_ctrl.sv
// Fetch/sequence controller: reads the vector line and ROWS matrix lines over Avalon-MM and serialises them into the B/A FIFOs.
// It then runs the MAC execute window. Define MATVEC_LOAD_TIMEOUT_EN to build the per-line read watchdog that drives err.
module matvec_load_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int COLS         = 8,
    parameter int ROWS         = 8,
    parameter int ADDR_WIDTH   = 32,
    parameter int BASE_ADDR    = 0,
    parameter int ADDR_INCR    = 1,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [ADDR_WIDTH-1:0]      avm_address,
    output logic                       avm_read,
    input  logic [DATA_WIDTH*COLS-1:0] avm_readdata,
    input  logic                       avm_readdatavalid,
    input  logic                       avm_waitrequest,
    output logic                       mac_clr,
    output logic                       b_wren,
    output logic [DATA_WIDTH-1:0]      b_data,
    output logic [ROWS-1:0]            a_wren,
    output logic [DATA_WIDTH-1:0]      a_data,
    output logic                       mac_en
);

    localparam int LW = $clog2(ROWS + 1);
    localparam int EW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int XW = $clog2(COLS + DRAIN_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_EXEC  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]                 state;
    logic [2:0]                 state_nxt;
    logic [LW-1:0]              line_cnt;
    logic [EW-1:0]              elem_cnt;
    logic [XW-1:0]              exec_cnt;
    logic [DATA_WIDTH*COLS-1:0] line_reg;
    logic                       first_req;
    logic [DATA_WIDTH-1:0]      elem;
    logic                       timeout;
    logic                       last_elem;
    logic                       shift_b;
    logic                       shift_a;

`ifdef MATVEC_LOAD_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        err_q;

    // Watchdog restarts on every REQ entry and spans both REQ and WAIT of one line.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_nxt == S_REQ && state != S_REQ)
                wd_cnt <= '0;
            else if (state == S_REQ || state == S_WAIT)
                wd_cnt <= wd_cnt + 16'd1;

            if ((state == S_IDLE || state == S_DONE) && start)
                err_q <= 1'b0;
            else if (timeout)
                err_q <= 1'b1;
        end
    end

    assign timeout = (state == S_REQ || (state == S_WAIT && !avm_readdatavalid))
                     && wd_cnt == 16'd1023;
    assign err     = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign last_elem = (elem_cnt == EW'(COLS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_REQ;
            S_REQ: begin
                if (timeout)
                    state_nxt = S_DONE;
                else if (!avm_waitrequest)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (avm_readdatavalid)
                    state_nxt = S_SHIFT;
                else if (timeout)
                    state_nxt = S_DONE;
            end
            S_SHIFT: begin
                if (last_elem)
                    state_nxt = (line_cnt == LW'(ROWS)) ? S_EXEC : S_REQ;
            end
            S_EXEC: begin
                if (exec_cnt == XW'(COLS + DRAIN_CYCLES - 1))
                    state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            line_cnt  <= '0;
            elem_cnt  <= '0;
            exec_cnt  <= '0;
            line_reg  <= '0;
            first_req <= 1'b0;
        end else begin
            state    <= state_nxt;
            exec_cnt <= (state == S_EXEC) ? exec_cnt + XW'(1) : '0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        line_cnt  <= '0;
                        first_req <= 1'b1;
                    end
                end
                S_REQ: first_req <= 1'b0;
                S_WAIT: begin
                    if (avm_readdatavalid) begin
                        line_reg <= avm_readdata;
                        elem_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    elem_cnt <= elem_cnt + EW'(1);
                    if (last_elem && line_cnt != LW'(ROWS))
                        line_cnt <= line_cnt + LW'(1);
                end
                default: ;
            endcase
        end
    end

    // Line 0 is the vector and goes to B; line L>=1 is matrix row L-1.
    assign elem    = line_reg[elem_cnt*DATA_WIDTH +: DATA_WIDTH];
    assign shift_b = (state == S_SHIFT) && (line_cnt == '0);
    assign shift_a = (state == S_SHIFT) && (line_cnt != '0);

    assign busy        = (state != S_IDLE) && (state != S_DONE);
    assign done        = (state == S_DONE);
    assign avm_read    = (state == S_REQ);
    assign avm_address = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(line_cnt) * ADDR_WIDTH'(ADDR_INCR);
    assign mac_clr     = (state == S_REQ) && first_req;
    assign b_wren      = shift_b;
    assign b_data      = shift_b ? elem : '0;
    assign a_wren      = shift_a ? (ROWS'(1) << (line_cnt - LW'(1))) : '0;
    assign a_data      = shift_a ? elem : '0;
    assign mac_en      = (state == S_EXEC) && (exec_cnt < XW'(COLS));

endmodule

// File: tb/tb_matvec_load_ctrl.sv
// Randomized bench for matvec_load_ctrl: a per-line timeline model (stall, latency, COLS) predicts every output cycle.
// Covers nominal/element-order/stall jobs, random jobs, mid-job reset and, with MATVEC_LOAD_TIMEOUT_EN, the watchdog.
module tb_matvec_load_ctrl;

    localparam int DW    = 8;
    localparam int COLS  = 8;
    localparam int ROWS  = 8;
    localparam int AW    = 32;
    localparam int DRAIN = 8;
    localparam int LINE  = DW * COLS;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          rd;
        logic [AW-1:0] addr;
        logic          clr;
        logic          bw;
        logic [DW-1:0] bd;
        logic [ROWS-1:0] aw;
        logic [DW-1:0] ad;
        logic          me;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy, done, err;
    logic [AW-1:0]   avm_address;
    logic            avm_read;
    logic [LINE-1:0] avm_readdata;
    logic            avm_readdatavalid;
    logic            avm_waitrequest;
    logic            mac_clr, b_wren, mac_en;
    logic [DW-1:0]   b_data, a_data;
    logic [ROWS-1:0] a_wren;

    always #5 clk = ~clk;

    matvec_load_ctrl #(
        .DATA_WIDTH(DW), .COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW),
        .BASE_ADDR(0), .ADDR_INCR(1), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .err(err),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest(avm_waitrequest),
        .mac_clr(mac_clr), .b_wren(b_wren), .b_data(b_data),
        .a_wren(a_wren), .a_data(a_data), .mac_en(mac_en)
    );

    logic [LINE-1:0] mem_q [0:ROWS];
    int stall_q    [0:ROWS];
    int lat_q      [0:ROWS];
    int stall_left [0:ROWS];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t0 = 0;
    int mode = 0;
    int pend_cnt = 0;
    int pend_line = 0;
    int resp_line = 0;
    logic stray = 1'b0;
    int accepts = 0;
    int line3_reads = 0;
    int b_cnt = 0;
    int a_total = 0;
    int me_cnt = 0;
    int a1_seen = 0;
    logic [DW-1:0] b_log [$];
    exp_t mexp;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First SHIFT cycle of line k, relative to the first REQ cycle.
    function automatic int shift_start(input int k);
        int base = 0;
        for (int j = 0; j < k; j++)
            base += stall_q[j] + 1 + lat_q[j] + COLS;
        return base + stall_q[k] + 1 + lat_q[k];
    endfunction

    function automatic int model_end();
        return shift_start(ROWS) + COLS + COLS + DRAIN;
    endfunction

    // Expected outputs t cycles after the job's first REQ cycle.
    function automatic exp_t model(input int t);
        exp_t x;
        int base;
        int req_len;
        int e;
        logic [LINE-1:0] ld;
        x = '0;
        x.busy = 1'b1;
        base = 0;
        for (int k = 0; k <= ROWS; k++) begin
            req_len = stall_q[k] + 1;
            if (t < base + req_len) begin
                x.rd   = 1'b1;
                x.addr = AW'(k);
                x.clr  = (t == 0);
                return x;
            end
            if (t < base + req_len + lat_q[k])
                return x;
            if (t < base + req_len + lat_q[k] + COLS) begin
                e  = t - (base + req_len + lat_q[k]);
                ld = mem_q[k];
                if (k == 0) begin
                    x.bw = 1'b1;
                    x.bd = ld[e*DW +: DW];
                end else begin
                    x.aw[k-1] = 1'b1;
                    x.ad      = ld[e*DW +: DW];
                end
                return x;
            end
            base += req_len + lat_q[k] + COLS;
        end
        if (t < base + COLS) begin
            x.me = 1'b1;
            return x;
        end
        if (t < base + COLS + DRAIN)
            return x;
        x.busy = 1'b0;
        x.done = 1'b1;
        return x;
    endfunction

    // Memory slave: stalls per stall_q, answers lat_q cycles after accept (lat 0 = never).
    initial forever begin
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        if (stray) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = '1;
            stray             = 1'b0;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = mem_q[pend_line];
            end
        end
        if (avm_read && !rst) begin
            resp_line = int'(avm_address);
            if (resp_line > ROWS) resp_line = 0;
            if (resp_line == 3) line3_reads++;
            if (stall_left[resp_line] > 0) begin
                avm_waitrequest = 1'b1;
                stall_left[resp_line]--;
            end else begin
                accepts++;
                pend_line = resp_line;
                pend_cnt  = lat_q[resp_line];
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (mode == 1) begin
            checkOutput("idle_outputs",
                {busy, done, err, avm_read, mac_clr, b_wren, mac_en, a_wren, b_data, a_data}, 64'd0);
            checkOutput("idle_address", avm_address, 64'd0);
        end else if (mode == 2) begin
            mexp = model(cyc - t0);
            checkOutput("ctrl", {busy, done, err, avm_read, mac_clr, mac_en},
                        {mexp.busy, mexp.done, 1'b0, mexp.rd, mexp.clr, mexp.me});
            checkOutput("b_port", {b_wren, b_data}, {mexp.bw, mexp.bd});
            checkOutput("a_port", {a_wren, a_data}, {mexp.aw, mexp.ad});
            if (mexp.rd) checkOutput("avm_address", avm_address, mexp.addr);
            if (b_wren) begin
                b_cnt++;
                b_log.push_back(b_data);
            end
            for (int r = 0; r < ROWS; r++)
                if (a_wren[r]) a_total++;
            if (mac_en) me_cnt++;
        end
        if (a_wren[1]) a1_seen++;
    end

    task automatic setup_fixed();
        for (int k = 0; k <= ROWS; k++) begin
            mem_q[k]   = {COLS{8'(k + 1)}};
            stall_q[k] = 0;
            lat_q[k]   = 1;
        end
    endtask

    task automatic setup_random(input int max_stall, input int max_lat);
        for (int k = 0; k <= ROWS; k++) begin
            mem_q[k]   = {$urandom, $urandom};
            stall_q[k] = $urandom_range(0, max_stall);
            lat_q[k]   = $urandom_range(1, max_lat);
        end
    endtask

    task automatic launch();
        for (int k = 0; k <= ROWS; k++) stall_left[k] = stall_q[k];
        b_cnt = 0; a_total = 0; me_cnt = 0; accepts = 0; line3_reads = 0;
        b_log.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        t0    = cyc;
        mode  = 2;
    endtask

    task automatic applyStimulus(input int extra_start_at);
        int endt;
        logic seen;
        endt = model_end();
        launch();
        seen = 1'b0;
        for (int i = 0; i < endt + 40 && !seen; i++) begin
            start = (i == extra_start_at);
            tick();
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) checkOutput("done_reached", 64'd0, 64'd1);
        repeat (2) tick();
        mode = 0;
        checkOutput("b_write_count", b_cnt, COLS);
        checkOutput("a_write_count", a_total, COLS * ROWS);
        checkOutput("mac_en_count", me_cnt, COLS);
        checkOutput("accept_count", accepts, ROWS + 1);
    endtask

    initial begin
        int sh4;
        rst = 1'b1; start = 1'b0;
        avm_readdata = '0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
        setup_fixed();
        repeat (3) tick();
        rst  = 1'b0;
        mode = 1;
        repeat (3) tick();
        mode = 0;
        checkOutput("reset_busy_done", {busy, done}, 64'd0);

        $display("[TB] nominal job");
        setup_fixed();
        checkOutput("model_done_offset", model_end(), 106);
        checkOutput("model_first_clr", model(0).clr, 1);
        checkOutput("model_row2_data", model(shift_start(3)).ad, 8'h04);
        applyStimulus(-1);
        for (int i = 0; i < b_log.size(); i++) checkOutput("b_data_nominal", b_log[i], 8'h01);

        $display("[TB] element order job");
        setup_fixed();
        mem_q[0] = 64'h0706050403020100;
        applyStimulus(-1);
        for (int i = 0; i < b_log.size(); i++) checkOutput("b_data_order", b_log[i], i);

        $display("[TB] waitrequest stall on line 3, plus a start while busy");
        setup_fixed();
        stall_q[3] = 5;
        applyStimulus(20);
        checkOutput("line3_read_cycles", line3_reads, 6);

        $display("[TB] random jobs");
        for (int j = 0; j < 5; j++) begin
            setup_random(3, 4);
            applyStimulus($urandom_range(0, 60));
        end

        $display("[TB] mid-job reset");
        setup_random(2, 3);
        sh4 = shift_start(4);
        launch();
        while (cyc - t0 < sh4 + 3) tick();
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        mode = 1;
        tick();
        stray = 1'b1;
        repeat (4) tick();
        mode = 0;
        setup_random(2, 3);
        applyStimulus(-1);

`ifdef MATVEC_LOAD_TIMEOUT_EN
        $display("[TB] read timeout");
        setup_fixed();
        lat_q[2] = 0;
        launch();
        mode = 0;
        a1_seen = 0;
        for (int i = 0; i < 1500 && !done; i++) tick();
        checkOutput("timeout_done_err", {done, err}, 64'h3);
        checkOutput("timeout_no_row1", a1_seen, 0);
        setup_fixed();
        applyStimulus(-1);
        checkOutput("err_cleared", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #800000;
        $display("[TB] FAIL global_time_limit: simulation did not finish, expected completion");
        $fatal(1, "[TB] time limit");
    end

endmodule
